// File: rtl/seq_mul_sm.sv
// Sign-magnitude shift-add multiplier: one partial product per clock.
// Latency: start edge k -> done pulse and new R in the cycle after edge k+MW+1.
// Handshake: start is only sampled in IDLE; requests while busy are dropped.
module seq_mul_sm #(
  parameter int WIDTH     = 3,
  parameter bit NORM_ZERO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-2:0] R
);

  localparam int MW = WIDTH - 1;
  localparam int AW = 2 * MW;
  // count only has to reach MW-1; keep at least one bit for the MW=1 case
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [MW-1:0]   mag_a;
  logic [MW-1:0]   mag_b;
  logic            sign;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            sign_out;

  // a zero product may be forced positive; otherwise -0 passes through as legacy
  assign sign_out = (NORM_ZERO && (acc == '0)) ? 1'b0 : sign;

  assign busy = (state != S_IDLE);

  // control FSM plus datapath; R and done are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
      R     <= '0;
      mag_a <= '0;
      mag_b <= '0;
      sign  <= 1'b0;
      acc   <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mag_a <= A[MW-1:0];
            mag_b <= B[MW-1:0];
            sign  <= A[WIDTH-1] ^ B[WIDTH-1];
            acc   <= '0;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // fixed MW iterations, no early exit on zero operands
          if (mag_b[count]) begin
            acc <= acc + (AW'(mag_a) << count);
          end
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          R     <= {sign_out, acc};
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_sm.sv
// Directed bench for seq_mul_sm: WIDTH=3 (both sign modes) and WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Each scenario task does its own comparisons and bumps the shared counters.
module tb_seq_mul_sm;

  logic clk = 1'b0;
  logic rst;

  logic       start3, busy3, done3;
  logic [2:0] a3, b3;
  logic [4:0] r3;

  logic       start3z, busy3z, done3z;
  logic [2:0] a3z, b3z;
  logic [4:0] r3z;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [14:0] r8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mul_sm #(.WIDTH(3), .NORM_ZERO(1'b0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3),
    .busy(busy3), .done(done3), .R(r3)
  );

  seq_mul_sm #(.WIDTH(3), .NORM_ZERO(1'b1)) u3z (
    .clk(clk), .rst(rst), .start(start3z), .A(a3z), .B(b3z),
    .busy(busy3z), .done(done3z), .R(r3z)
  );

  seq_mul_sm #(.WIDTH(8), .NORM_ZERO(1'b0)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .R(r8)
  );

  task automatic test_reset();
    rst = 1'b1;
    start3 = 1'b0; a3 = '0; b3 = '0;
    start3z = 1'b0; a3z = '0; b3z = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || r3 !== 5'b0) begin
      errors++;
      $display("FAIL reset_w3: busy=%b done=%b R=%b, want 0 0 00000", busy3, done3, r3);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || r8 !== 15'h0) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b R=%h, want 0 0 0000", busy8, done8, r8);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    a3 = 3'b011; b3 = 3'b111; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    checks++;
    if (busy3 !== 1'b1 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b done=%b, want 1 0", busy3, done3);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done3 && n < 20);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 3", n);
    end
    checks++;
    if (r3 !== 5'b11001) begin
      errors++;
      $display("FAIL basic_result: R=%b, want 11001", r3);
    end
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b after pulse, want 0 0", done3, busy3);
    end
  endtask

  task automatic test_exhaustive();
    int n;
    logic [3:0] ma, mb;
    logic [4:0] exp;
    a3 = 3'd0; b3 = 3'd0; start3 = 1'b1;
    for (int p = 0; p < 64; p++) begin
      a3 = p[5:3];
      b3 = p[2:0];
      ma = {2'b00, a3[1:0]};
      mb = {2'b00, b3[1:0]};
      exp = {a3[2] ^ b3[2], ma * mb};
      // accept edge: previous done must already be gone
      @(posedge clk); #1;
      checks++;
      if (done3 !== 1'b0 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL exh_accept[%0d]: done=%b busy=%b, want 0 1", p, done3, busy3);
      end
      n = 1;
      while (!done3 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 4 || r3 !== exp) begin
        errors++;
        $display("FAIL exh[%0d] A=%b B=%b: R=%b after %0d, want %b after 4", p, a3, b3, r3, n, exp);
      end
    end
    start3 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b0) begin
      errors++;
      $display("FAIL exh_last_pulse: done=%b, want 0", done3);
    end
  endtask

  task automatic test_wide();
    int n;
    a8 = 8'h7F; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done8 && n < 40);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL wide_latency: got %0d cycles, want 8", n);
    end
    checks++;
    if (r8 !== 15'h7F01) begin
      errors++;
      $display("FAIL wide_result: R=%h, want 7f01", r8);
    end
  endtask

  task automatic test_zero_sign();
    int n;
    logic [2:0] za [2];
    logic [2:0] zb [2];
    za[0] = 3'b000; zb[0] = 3'b110;
    za[1] = 3'b100; zb[1] = 3'b010;
    for (int v = 0; v < 2; v++) begin
      a3 = za[v]; b3 = zb[v]; a3z = za[v]; b3z = zb[v];
      start3 = 1'b1; start3z = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0; start3z = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done3 && n < 20);
      checks++;
      if (n !== 3 || r3 !== 5'b10000) begin
        errors++;
        $display("FAIL zero_legacy[%0d]: R=%b after %0d, want 10000 after 3", v, r3, n);
      end
      checks++;
      if (done3z !== 1'b1 || r3z !== 5'b00000) begin
        errors++;
        $display("FAIL zero_norm[%0d]: done=%b R=%b, want 1 00000", v, done3z, r3z);
      end
    end
  endtask

  task automatic test_handshake();
    int n;
    a3 = 3'b011; b3 = 3'b010; start3 = 1'b1;
    @(posedge clk); #1;
    // conflicting request while busy: must be dropped
    a3 = 3'b111; b3 = 3'b111;
    @(posedge clk); #1;
    start3 = 1'b0;
    a3 = 3'b000; b3 = 3'b000;
    @(posedge clk); #1;
    // now in DONE: raise start with the second operands
    a3 = 3'b001; b3 = 3'b101; start3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b1 || r3 !== 5'b00110) begin
      errors++;
      $display("FAIL hs_first: done=%b R=%b, want 1 00110", done3, r3);
    end
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL hs_spacing: second done %0d cycles after first, want 4", n);
    end
    checks++;
    if (r3 !== 5'b10001) begin
      errors++;
      $display("FAIL hs_second: R=%b, want 10001", r3);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    a3 = 3'b011; b3 = 3'b011; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || r3 !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b R=%b, want 0 0 00000", busy3, done3, r3);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done3 !== 1'b0 || busy3 !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_quiet: %0d cycles with activity after reset, want 0", seen);
    end
    a3 = 3'b010; b3 = 3'b110; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done3 && n < 20);
    checks++;
    if (n !== 3 || r3 !== 5'b10100) begin
      errors++;
      $display("FAIL rst_recover: R=%b after %0d, want 10100 after 3", r3, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exhaustive();
    test_wide();
    test_zero_sign();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
